// File: rtl/yutorina_bus_slave_sel_pkg.sv
// Shared definitions for the bus slave-select decoder: FSM state encodings and
// the location of the slave-index field inside the word address.
package yutorina_bus_slave_sel_pkg;

    typedef enum logic [1:0] {
        BUS_SEL_IDLE   = 2'd0,
        BUS_SEL_ACCESS = 2'd1,
        BUS_SEL_ERR    = 2'd2
    } bus_sel_state_e;

    // The slave index occupies the top idx_w bits of the word address.
    function automatic int slave_index_lsb(input int addr_w, input int idx_w);
        return addr_w - idx_w;
    endfunction

endpackage

// File: rtl/yutorina_bus_watchdog.sv
// Access watchdog: up-counter with clear/enable whose expire flag marks the last
// permitted wait cycle. TIMEOUT = 0 keeps expire low permanently.
module yutorina_bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset_,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/yutorina_bus_slave_sel.sv
// Bus slave-select decoder: turns the upper address bits into one-hot active-low
// chip selects, waits for the selected slave's rdy_, and converts unmapped or hung
// accesses into a one-cycle bus error so the master never stalls.
module yutorina_bus_slave_sel
    import yutorina_bus_slave_sel_pkg::*;
#(
    parameter int                  ADDR_W   = 30,
    parameter int                  IDX_W    = 3,
    parameter int                  N_SLAVES = 8,
    parameter logic [N_SLAVES-1:0] SLV_MAP  = {N_SLAVES{1'b1}},
    parameter int                  TIMEOUT  = 255,
    parameter int                  CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic                s_as_,
    input  logic [N_SLAVES-1:0] s_rdy_,
    output logic [N_SLAVES-1:0] s_cs_,
    output logic                m_rdy_,
    output logic                bus_err,
    output logic [ADDR_W-1:0]   err_addr
);

    localparam int IDX_LSB = slave_index_lsb(ADDR_W, IDX_W);

    bus_sel_state_e      state_q, state_d;
    logic [N_SLAVES-1:0] s_cs_q, s_cs_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic [IDX_W-1:0]    idx;
    logic [N_SLAVES-1:0] hit;
    logic                sel_rdy_;
    logic                wd_clr;
    logic                wd_en;
    logic                wd_expire;

    assign idx = s_addr[IDX_LSB +: IDX_W];

    // A slot hits only if the index matches and the slot is populated; an index
    // at or beyond N_SLAVES matches nothing and therefore errors.
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
            assign hit[gi] = (idx == IDX_W'(gi)) && SLV_MAP[gi];
        end
    endgenerate

    // The latched chip select masks out rdy_ from every non-selected slave.
    assign sel_rdy_ = ~|(~s_rdy_ & ~s_cs_q);

    yutorina_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_  (reset_),
        .clr     (wd_clr),
        .en      (wd_en),
        .expire  (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        s_cs_d     = s_cs_q;
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            BUS_SEL_IDLE: begin
                if (!s_as_) begin
                    addr_d = s_addr;
                    if (|hit) begin
                        s_cs_d  = ~hit;
                        wd_clr  = 1'b1;
                        state_d = BUS_SEL_ACCESS;
                    end else begin
                        err_addr_d = s_addr;
                        state_d    = BUS_SEL_ERR;
                    end
                end
            end
            BUS_SEL_ACCESS: begin
                // A ready in the final watchdog cycle still completes normally.
                if (!sel_rdy_) begin
                    s_cs_d  = '1;
                    state_d = BUS_SEL_IDLE;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        err_addr_d = addr_q;
                        s_cs_d     = '1;
                        state_d    = BUS_SEL_ERR;
                    end
                end
            end
            BUS_SEL_ERR: begin
                s_cs_d  = '1;
                state_d = BUS_SEL_IDLE;
            end
            default: begin
                s_cs_d  = '1;
                state_d = BUS_SEL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= BUS_SEL_IDLE;
            s_cs_q     <= '1;
            addr_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            s_cs_q     <= s_cs_d;
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign s_cs_    = s_cs_q;
    assign m_rdy_   = (state_q == BUS_SEL_ACCESS) ? sel_rdy_ : (state_q != BUS_SEL_ERR);
    assign bus_err  = (state_q == BUS_SEL_ERR);
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_yutorina_bus_slave_sel.sv
// Scoreboard bench for yutorina_bus_slave_sel: three parameterisations driven with
// random transactions, expectations derived from the decode/timeout rules.
`timescale 1ns/1ps
module tb_yutorina_bus_slave_sel;

    localparam int AW = 30;

    logic clk    = 1'b0;
    logic reset_ = 1'b1;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic          as0 = 1'b1, as1 = 1'b1, as2 = 1'b1;
    logic [7:0]    rdy0 = 8'hFF, rdy1 = 8'hFF;
    logic [4:0]    rdy2 = 5'h1F;
    logic [7:0]    cs0, cs1;
    logic [4:0]    cs2;
    logic          mr0, mr1, mr2;
    logic          be0, be1, be2;
    logic [AW-1:0] ea0, ea1, ea2;

    yutorina_bus_slave_sel dut0 (
        .clk(clk), .reset_(reset_), .s_addr(addr0), .s_as_(as0), .s_rdy_(rdy0),
        .s_cs_(cs0), .m_rdy_(mr0), .bus_err(be0), .err_addr(ea0)
    );

    yutorina_bus_slave_sel #(.SLV_MAP(8'h7F), .TIMEOUT(4)) dut1 (
        .clk(clk), .reset_(reset_), .s_addr(addr1), .s_as_(as1), .s_rdy_(rdy1),
        .s_cs_(cs1), .m_rdy_(mr1), .bus_err(be1), .err_addr(ea1)
    );

    yutorina_bus_slave_sel #(.IDX_W(4), .N_SLAVES(5), .SLV_MAP(5'h1F), .TIMEOUT(6)) dut2 (
        .clk(clk), .reset_(reset_), .s_addr(addr2), .s_as_(as2), .s_rdy_(rdy2),
        .s_cs_(cs2), .m_rdy_(mr2), .bus_err(be2), .err_addr(ea2)
    );

    typedef struct {
        int            issue;
        int            lat;
        logic          err;
        logic [AW-1:0] eaddr;
        logic [7:0]    cs_acc;
        logic [7:0]    cs_done;
    } exp_t;

    exp_t          q0[$], q1[$], q2[$];
    logic [AW-1:0] last_err[3];
    bit            mon_en[3];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int cfg_n(int k);
        return (k == 2) ? 5 : 8;
    endfunction
    function automatic int cfg_iw(int k);
        return (k == 2) ? 4 : 3;
    endfunction
    function automatic logic [7:0] cfg_map(int k);
        return (k == 1) ? 8'h7F : ((k == 2) ? 8'h1F : 8'hFF);
    endfunction
    function automatic int cfg_to(int k);
        return (k == 1) ? 4 : ((k == 2) ? 6 : 255);
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : ((k == 1) ? q1.size() : q2.size());
    endfunction
    function automatic exp_t q_front(int k);
        exp_t e;
        if (k == 0) e = q0[0];
        else if (k == 1) e = q1[0];
        else e = q2[0];
        return e;
    endfunction
    task automatic q_pop(int k);
        if (k == 0) q0.delete(0);
        else if (k == 1) q1.delete(0);
        else q2.delete(0);
    endtask
    task automatic q_push(int k, exp_t e);
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic set_in(int k, logic as, logic [AW-1:0] a, logic [7:0] r);
        case (k)
            0: begin as0 = as; addr0 = a; rdy0 = r; end
            1: begin as1 = as; addr1 = a; rdy1 = r; end
            default: begin as2 = as; addr2 = a; rdy2 = r[4:0]; end
        endcase
    endtask

    task automatic get_out(int k, output logic [7:0] cs, output logic mr, output logic be,
                           output logic [AW-1:0] ea);
        case (k)
            0: begin cs = cs0; mr = mr0; be = be0; ea = ea0; end
            1: begin cs = cs1; mr = mr1; be = be1; ea = ea1; end
            default: begin cs = {3'b111, cs2}; mr = mr2; be = be2; ea = ea2; end
        endcase
    endtask

    // One access, started at the beginning of an IDLE cycle. d = cycle of the
    // ACCESS phase (1-based) in which the selected slave answers; 0 = never.
    task automatic txn(int k, logic [AW-1:0] a, int d);
        exp_t       e;
        int         idx, t;
        logic       mapped;
        logic [7:0] map;
        logic [7:0] r;
        t      = cfg_to(k);
        map    = cfg_map(k);
        idx    = int'(a >> (AW - cfg_iw(k)));
        mapped = 1'b0;
        if (idx < cfg_n(k)) mapped = map[idx];
        e.issue = cyc;
        if (!mapped) begin
            e.lat    = 1;
            e.err    = 1'b1;
            e.cs_acc = 8'hFF;
        end else begin
            e.cs_acc = ~(8'h01 << idx);
            if (t != 0 && (d <= 0 || d > t)) begin
                e.lat = t + 1;
                e.err = 1'b1;
            end else begin
                e.lat = d;
                e.err = 1'b0;
            end
        end
        e.cs_done = e.err ? 8'hFF : e.cs_acc;
        if (e.err) last_err[k] = a;
        e.eaddr = last_err[k];
        q_push(k, e);
        set_in(k, 1'b0, a, 8'($urandom));
        for (int j = 1; j <= e.lat; j++) begin
            @(posedge clk); #1;
            r = 8'($urandom);
            if (mapped) r[idx] = (j == d) ? 1'b0 : 1'b1;
            set_in(k, 1'b1, AW'($urandom), r);
        end
        @(posedge clk); #1;
        set_in(k, 1'b1, AW'($urandom), 8'($urandom));
    endtask

    task automatic monitor(int k);
        logic [7:0]    cs;
        logic          mr, be, active;
        logic [AW-1:0] ea;
        exp_t          e;
        int            age;
        forever begin
            @(negedge clk);
            if (!mon_en[k]) continue;
            get_out(k, cs, mr, be, ea);
            chk("cs_onehot", k, 32'($countones(~cs) <= 1), 32'd1);
            active = 1'b0;
            if (q_size(k) != 0) begin
                e      = q_front(k);
                active = (cyc > e.issue);
            end
            if (active) begin
                age = cyc - e.issue;
                if (!mr) begin
                    chk("latency", k, 32'(age), 32'(e.lat));
                    chk("bus_err", k, 32'(be), 32'(e.err));
                    chk("err_addr", k, 32'(ea), 32'(e.eaddr));
                    chk("cs_done", k, 32'(cs), 32'(e.cs_done));
                    q_pop(k);
                end else begin
                    chk("cs_access", k, 32'(cs), 32'(e.cs_acc));
                    chk("bus_err_wait", k, 32'(be), 32'd0);
                    if (age >= e.lat) begin
                        chk("m_rdy_due", k, 32'(mr), 32'd0);
                        q_pop(k);
                    end
                end
            end else begin
                chk("cs_idle", k, 32'(cs), 32'hFF);
                chk("m_rdy_idle", k, 32'(mr), 32'd1);
                chk("bus_err_idle", k, 32'(be), 32'd0);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0]    cs;
        logic          mr, be;
        logic [AW-1:0] ea;
        int            t;
        for (int k = 0; k < 3; k++) begin
            mon_en[k]   = 1'b1;
            last_err[k] = '0;
        end
        #1 reset_ = 1'b0;
        #11;
        for (int k = 0; k < 3; k++) begin
            get_out(k, cs, mr, be, ea);
            chk("rst_cs", k, 32'(cs), 32'hFF);
            chk("rst_m_rdy", k, 32'(mr), 32'd1);
            chk("rst_bus_err", k, 32'(be), 32'd0);
            chk("rst_err_addr", k, 32'(ea), 32'd0);
        end
        @(posedge clk); #1 reset_ = 1'b1;
        @(posedge clk); #1;

        txn(0, 30'h1000_0000, 3);          // idx 2, answers in 3rd ACCESS cycle
        txn(1, 30'h3800_0000, 1);          // idx 7 unmapped
        txn(1, 30'h0800_0000, 0);          // idx 1 hung -> timeout
        txn(1, 30'h0800_0004, 4);          // ready on last watchdog cycle
        txn(2, 30'h1400_0000, 1);          // idx 5 >= N_SLAVES
        txn(2, 30'h3C00_0000, 1);          // idx 15
        txn(2, 30'h1000_0000, 2);          // idx 4
        txn(0, 30'h2000_0010, 0);          // full 255-cycle timeout
        txn(0, 30'h0000_0020, 1);          // back-to-back minimum access
        txn(0, 30'h0800_0030, 1);

        for (int k = 0; k < 3; k++) begin
            t = cfg_to(k);
            for (int i = 0; i < 30; i++) begin
                if (k == 0) txn(k, AW'($urandom), int'($urandom_range(1, 6)));
                else txn(k, AW'($urandom), int'($urandom_range(0, t + 2)));
                idle_gap();
            end
        end

        // Asynchronous reset in the middle of an access on instance 0.
        mon_en[0] = 1'b0;
        set_in(0, 1'b0, 30'h1800_0000, 8'hFF);
        @(posedge clk); #1 set_in(0, 1'b1, 30'h0, 8'hFF);
        @(posedge clk); #1;
        get_out(0, cs, mr, be, ea);
        chk("pre_rst_cs", 0, 32'(cs), 32'hF7);
        #3 reset_ = 1'b0;
        #1;
        get_out(0, cs, mr, be, ea);
        chk("async_rst_cs", 0, 32'(cs), 32'hFF);
        chk("async_rst_m_rdy", 0, 32'(mr), 32'd1);
        for (int k = 0; k < 3; k++) begin
            last_err[k] = '0;
            get_out(k, cs, mr, be, ea);
            chk("async_rst_err_addr", k, 32'(ea), 32'd0);
        end
        @(posedge clk); #1 reset_ = 1'b1;
        mon_en[0] = 1'b1;
        @(posedge clk); #1;
        txn(0, 30'h2800_0000, 2);          // idx 5 right after reset
        txn(0, 30'h3800_0000, 1);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("sb_drain", k, 32'(q_size(k)), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
